// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback decoder.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  // Active-high segment patterns, bit order gfedcba.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [BCD_W-1:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Decoded digit plus illegal-pattern flag.
  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             err;
  } dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output dec_t             dec_c
);

  // Table lookup; anything outside the ten digits and blank is illegal.
  always_comb begin
    dec_c.bcd = BCD_ERR;
    dec_c.err = 1'b1;
    unique case (seg)
      SEG_0:     begin dec_c.bcd = 4'd0;      dec_c.err = 1'b0; end
      SEG_1:     begin dec_c.bcd = 4'd1;      dec_c.err = 1'b0; end
      SEG_2:     begin dec_c.bcd = 4'd2;      dec_c.err = 1'b0; end
      SEG_3:     begin dec_c.bcd = 4'd3;      dec_c.err = 1'b0; end
      SEG_4:     begin dec_c.bcd = 4'd4;      dec_c.err = 1'b0; end
      SEG_5:     begin dec_c.bcd = 4'd5;      dec_c.err = 1'b0; end
      SEG_6:     begin dec_c.bcd = 4'd6;      dec_c.err = 1'b0; end
      SEG_7:     begin dec_c.bcd = 4'd7;      dec_c.err = 1'b0; end
      SEG_8:     begin dec_c.bcd = 4'd8;      dec_c.err = 1'b0; end
      SEG_9:     begin dec_c.bcd = 4'd9;      dec_c.err = 1'b0; end
      SEG_BLANK: begin dec_c.bcd = BCD_BLANK; dec_c.err = 1'b0; end
      default:   begin dec_c.bcd = BCD_ERR;   dec_c.err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_digit_decoder.sv
// Watches a multiplexed 7-segment bus and emits one BCD beat per stable digit window.
module seg7_digit_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE     = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NDIG-1:0]         dig_sel,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [BCD_W-1:0]        m_bcd,
  output logic [$clog2(NDIG)-1:0] m_idx,
  output logic                    m_err,
  output logic                    ovf
);

  localparam int unsigned IDX_W = $clog2(NDIG);
  localparam int unsigned CNT_W = $clog2(STABLE + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam int unsigned ENT_W = BCD_W + IDX_W + 1;

  logic [SEG_W-1:0] seg_q;
  logic [NDIG-1:0]  sel_q;
  logic [SEG_W-1:0] pat_q;
  logic [NDIG-1:0]  lat_q;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  logic             onehot_c;
  logic             match_c;
  logic             relatch_c;
  logic             push_c;
  logic [IDX_W-1:0] idx_c;
  dec_t             dec_c;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty_c;
  logic             full_c;
  logic             pop_c;
  logic             wr_en_c;

  // Input stage: the FSM only ever looks at these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
    end
  end

  // Sample classification and one-hot to binary index.
  always_comb begin
    onehot_c  = (sel_q != '0) && ((sel_q & (sel_q - NDIG'(1))) == '0);
    match_c   = (seg_q == pat_q) && (sel_q == lat_q);
    relatch_c = onehot_c && ((state == IDLE) || !match_c);
    push_c    = (relatch_c && (STABLE == 1)) ||
                ((state == TRACK) && match_c && ((32'(cnt) + 32'd1) >= STABLE));
    idx_c     = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (sel_q[i]) idx_c = IDX_W'(i);
    end
  end

  // Every push happens on a sample equal to the latched window, so decoding the
  // sample gives the latched payload and keeps STABLE==1 pushes in the same cycle.
  seg7_decode u_decode (
    .seg   (seg_q),
    .dec_c (dec_c)
  );

  // Window tracking FSM with saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= '0;
      lat_q <= '0;
      cnt   <= '0;
    end else if (relatch_c) begin
      pat_q <= seg_q;
      lat_q <= sel_q;
      cnt   <= CNT_W'(1);
      state <= (STABLE == 1) ? HOLD : TRACK;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        TRACK: begin
          if (match_c) begin
            if (32'(cnt) < STABLE) cnt <= cnt + CNT_W'(1);
            if (push_c) state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (!match_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO status; the extra pointer bit separates full from empty.
  always_comb begin
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    pop_c   = !empty_c && m_ready;
    wr_en_c = push_c && (!full_c || pop_c);
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr[PTR_W-1:0]] <= {dec_c.bcd, idx_c, dec_c.err};
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push_c && full_c && !pop_c) ovf <= 1'b1;
    end
  end

  // Outputs come straight from storage; no write-through path.
  assign m_valid = !empty_c;
  assign {m_bcd, m_idx, m_err} = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Directed self-checking bench for seg7_digit_decoder and seg7_decode.
module tb_seg7_digit_decoder;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] dig_sel;
  logic       m_ready;
  logic       m_valid;
  logic [3:0] m_bcd;
  logic [1:0] m_idx;
  logic       m_err;
  logic       ovf;

  logic [6:0] sw_seg;
  dec_t       sw_dec;

  int n_assert = 0;
  int n_fail   = 0;
  logic [6:0] beats[$];

  seg7_digit_decoder #(.NDIG(4), .STABLE(3), .FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_in  (seg_in),
    .dig_sel (dig_sel),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_bcd   (m_bcd),
    .m_idx   (m_idx),
    .m_err   (m_err),
    .ovf     (ovf)
  );

  seg7_decode u_sweep (
    .seg   (sw_seg),
    .dec_c (sw_dec)
  );

  always #5 clk = ~clk;

  // Record every handshake away from the active edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) beats.push_back({m_bcd, m_idx, m_err});
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d);
    seg_in  = s;
    dig_sel = d;
  endtask

  function automatic logic [6:0] beat(input logic [3:0] b, input logic [1:0] i, input logic e);
    return {b, i, e};
  endfunction

  function automatic logic [4:0] exp_dec(input logic [6:0] s);
    case (s)
      7'h3F:   return {4'h0, 1'b0};
      7'h06:   return {4'h1, 1'b0};
      7'h5B:   return {4'h2, 1'b0};
      7'h4F:   return {4'h3, 1'b0};
      7'h66:   return {4'h4, 1'b0};
      7'h6D:   return {4'h5, 1'b0};
      7'h7D:   return {4'h6, 1'b0};
      7'h07:   return {4'h7, 1'b0};
      7'h7F:   return {4'h8, 1'b0};
      7'h6F:   return {4'h9, 1'b0};
      7'h00:   return {4'hF, 1'b0};
      default: return {4'hE, 1'b1};
    endcase
  endfunction

  initial begin
    rst_n   = 1'b1;
    m_ready = 1'b1;
    drive(7'h00, 4'b0000);
    sw_seg  = 7'h00;

    // Decoder sweep over all 128 patterns.
    for (int i = 0; i < 128; i++) begin
      sw_seg = 7'(i);
      #1;
      check("decode_sweep", 32'({sw_dec.bcd, sw_dec.err}), 32'(exp_dec(7'(i))));
    end

    // 1: asynchronous reset mid-cycle, then idle bus.
    step(2);
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_ovf",   32'(ovf),     32'(0));
    check("rst_bcd",   32'(m_bcd),   32'(0));
    check("rst_idx",   32'(m_idx),   32'(0));
    check("rst_err",   32'(m_err),   32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(5);
    check("idle_no_beat", 32'(beats.size()), 32'(0));
    check("idle_valid",   32'(m_valid),      32'(0));

    // 2: digit 2 on strobe 2, latency and single beat.
    drive(7'h5B, 4'b0100);
    step(3);
    check("lat_valid_e3", 32'(m_valid), 32'(0));
    step(1);
    check("lat_valid_e4", 32'(m_valid), 32'(1));
    check("t2_bcd", 32'(m_bcd), 32'(2));
    check("t2_idx", 32'(m_idx), 32'(2));
    check("t2_err", 32'(m_err), 32'(0));
    step(4);
    drive(7'h00, 4'b0000);
    step(3);
    check("t2_count", 32'(beats.size()), 32'(1));
    if (beats.size() > 0) check("t2_beat", 32'(beats[0]), 32'(beat(4'd2, 2'd2, 1'b0)));
    check("t2_drained", 32'(m_valid), 32'(0));
    beats.delete();

    // 3: short glitch window rejected, following digit captured.
    drive(7'h6F, 4'b0001);
    step(2);
    drive(7'h06, 4'b0010);
    step(5);
    drive(7'h00, 4'b0000);
    step(3);
    check("t3_count", 32'(beats.size()), 32'(1));
    if (beats.size() > 0) check("t3_beat", 32'(beats[0]), 32'(beat(4'd1, 2'd1, 1'b0)));
    beats.delete();

    // 4: illegal pattern then blank.
    drive(7'h49, 4'b1000);
    step(5);
    drive(7'h00, 4'b0001);
    step(5);
    drive(7'h00, 4'b0000);
    step(3);
    check("t4_count", 32'(beats.size()), 32'(2));
    if (beats.size() > 1) begin
      check("t4_illegal", 32'(beats[0]), 32'(beat(4'hE, 2'd3, 1'b1)));
      check("t4_blank",   32'(beats[1]), 32'(beat(4'hF, 2'd0, 1'b0)));
    end
    beats.delete();

    // 5: stalled output, overflow on third window, ordered drain.
    m_ready = 1'b0;
    drive(7'h3F, 4'b0001);
    step(5);
    check("t5_valid", 32'(m_valid), 32'(1));
    check("t5_bcd_a", 32'(m_bcd),   32'(0));
    drive(7'h06, 4'b0010);
    step(5);
    check("t5_bcd_b", 32'(m_bcd), 32'(0));
    check("t5_idx_b", 32'(m_idx), 32'(0));
    check("t5_ovf_b", 32'(ovf),   32'(0));
    drive(7'h5B, 4'b0100);
    step(5);
    check("t5_ovf_c", 32'(ovf),   32'(1));
    check("t5_bcd_c", 32'(m_bcd), 32'(0));
    check("t5_idx_c", 32'(m_idx), 32'(0));
    drive(7'h00, 4'b0000);
    step(2);
    m_ready = 1'b1;
    step(3);
    check("t5_count", 32'(beats.size()), 32'(2));
    if (beats.size() > 1) begin
      check("t5_first",  32'(beats[0]), 32'(beat(4'd0, 2'd0, 1'b0)));
      check("t5_second", 32'(beats[1]), 32'(beat(4'd1, 2'd1, 1'b0)));
    end
    check("t5_empty",  32'(m_valid), 32'(0));
    check("t5_sticky", 32'(ovf),     32'(1));
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_ovf",   32'(ovf),     32'(0));
    check("t5_rst_valid", 32'(m_valid), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    beats.delete();

    // 6: multi-hot strobe ignored; reset discards a window in progress.
    drive(7'h7F, 4'b0110);
    step(6);
    check("t6_multihot", 32'(beats.size()), 32'(0));
    check("t6_mh_valid", 32'(m_valid),      32'(0));
    drive(7'h07, 4'b0001);
    step(2);
    check("t6_tracking", 32'(dut.state), 32'(TRACK));
    #3 rst_n = 1'b0;
    drive(7'h00, 4'b0000);
    #1;
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(5);
    check("t6_no_beat", 32'(beats.size()), 32'(0));
    check("t6_valid",   32'(m_valid),      32'(0));
    check("t6_idle",    32'(dut.state),    32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
